// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: receive-side 1:4 TDM demux steering framed words into four lane registers.
// Define TDM_DEMUX_PARITY_EN to add even-parity checking (din_par in, par_err out).
module tdm_demux_1to4 #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   din,
   input  logic               din_valid,
   input  logic               frame_sync,
   output logic [4*WIDTH-1:0] dout,
   output logic [3:0]         lane_valid,
   output logic [1:0]         slot,
   output logic               locked,
   output logic               frame_done,
   output logic               sync_err
`ifdef TDM_DEMUX_PARITY_EN
   ,
   input  logic               din_par,
   output logic               par_err
`endif
);
   typedef enum logic {HUNT, LOCK} state_t;
   state_t state, state_n;
   logic [1:0] slot_n, wr_slot;
   logic [4*WIDTH-1:0] dout_n;
   logic [3:0] lane_valid_n;
   logic accept, good, write, frame_done_n, sync_err_n, par_err_n;
`ifdef TDM_DEMUX_PARITY_EN
   assign good = ~^{din, din_par};
`else
   assign good = 1'b1;
`endif
   assign locked = state == LOCK;
   always_comb begin
      accept = din_valid && (state == LOCK || frame_sync);
      // a qualified frame_sync always forces slot 0, which both acquires and realigns
      wr_slot = frame_sync ? 2'd0 : slot;
      write = accept && good;
      state_n = accept ? LOCK : state;
      slot_n = accept ? wr_slot + 2'd1 : slot;
      dout_n = dout;
      if (write)
         dout_n[wr_slot*WIDTH +: WIDTH] = din;
      lane_valid_n = write ? 4'b0001 << wr_slot : 4'b0000;
      frame_done_n = accept && wr_slot == 2'd3;
      sync_err_n = accept && state == LOCK && frame_sync && slot != 2'd0;
      par_err_n = accept && !good;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HUNT;
         slot <= 2'd0;
         dout <= '0;
         lane_valid <= 4'b0000;
         frame_done <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         state <= state_n;
         slot <= slot_n;
         dout <= dout_n;
         lane_valid <= lane_valid_n;
         frame_done <= frame_done_n;
         sync_err <= sync_err_n;
      end
   end
`ifdef TDM_DEMUX_PARITY_EN
   always_ff @(posedge clk)
      par_err <= rst ? 1'b0 : par_err_n;
`else
   logic unused;
   assign unused = par_err_n;
`endif
endmodule

// File: tb/tb_tdm_demux_1to4.sv
// tb_tdm_demux_1to4: scoreboard bench for tdm_demux_1to4 against a lane-array reference model.
// Works with or without TDM_DEMUX_PARITY_EN defined.
module tb_tdm_demux_1to4;
   localparam int W = 8;
   logic clk = 0, rst = 1, din_valid = 0, frame_sync = 0, din_par = 0;
   logic [W-1:0] din = '0;
   logic [4*W-1:0] dout;
   logic [3:0] lane_valid;
   logic [1:0] slot;
   logic locked, frame_done, sync_err, par_err;

   tdm_demux_1to4 #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
      .dout(dout), .lane_valid(lane_valid), .slot(slot), .locked(locked),
      .frame_done(frame_done), .sync_err(sync_err)
`ifdef TDM_DEMUX_PARITY_EN
      , .din_par(din_par), .par_err(par_err)
`endif
   );
`ifndef TDM_DEMUX_PARITY_EN
   assign par_err = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4*W-1:0] dout;
      logic [3:0] lv;
      logic [1:0] slot;
      logic locked, fd, serr, perr;
   } obs_t;

   obs_t q[$];
   int checks = 0, errors = 0;
   int m_slot = 0;
   bit m_lock = 0;
   logic [W-1:0] m_lane[4] = '{default: '0};

   // Reference: each negedge drive predicts the outputs after the following posedge
   task automatic step(bit r, bit v, bit fs, logic [W-1:0] d, bit bad);
      obs_t e;
      int s;
      @(negedge clk);
      rst = r; din_valid = v; frame_sync = fs; din = d; din_par = (^d) ^ bad;
`ifndef TDM_DEMUX_PARITY_EN
      bad = 0;
`endif
      e = '0;
      if (r) begin
         m_slot = 0; m_lock = 0;
         for (int i = 0; i < 4; i++) m_lane[i] = '0;
      end else if (v && (m_lock || fs)) begin
         s = fs ? 0 : m_slot;
         e.serr = m_lock && fs && m_slot != 0;
         if (bad) e.perr = 1;
         else begin
            m_lane[s] = d;
            e.lv[s] = 1'b1;
         end
         e.fd = s == 3;
         m_slot = (s + 1) % 4;
         m_lock = 1;
      end
      e.dout = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
      e.slot = m_slot[1:0];
      e.locked = m_lock;
      q.push_back(e);
   endtask

   always @(posedge clk) begin
      obs_t a, e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         a = {dout, lane_valid, slot, locked, frame_done, sync_err, par_err};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs t=%0t got dout=%h lv=%b slot=%0d lock=%b fd=%b serr=%b perr=%b exp dout=%h lv=%b slot=%0d lock=%b fd=%b serr=%b perr=%b",
               $time, a.dout, a.lv, a.slot, a.locked, a.fd, a.serr, a.perr,
               e.dout, e.lv, e.slot, e.locked, e.fd, e.serr, e.perr);
         end
      end
   end

   initial begin
      int n;
      step(1, 0, 0, 8'h00, 0); step(1, 0, 0, 8'h00, 0);
      step(0, 1, 1, 8'hA1, 0); step(0, 1, 0, 8'hB2, 0);
      step(0, 1, 0, 8'hC3, 0); step(0, 1, 0, 8'hD4, 0);
      step(0, 0, 0, 8'h00, 0);
      step(1, 0, 0, 8'h00, 0);
      step(0, 1, 0, 8'h11, 0); step(0, 1, 0, 8'h22, 0);
      step(0, 1, 0, 8'h33, 0); step(0, 1, 1, 8'h44, 0);
      step(0, 1, 0, 8'h55, 0); step(0, 1, 1, 8'h5A, 0);
      step(0, 1, 0, 8'h66, 0); step(0, 0, 1, 8'hEE, 0);
      step(0, 1, 0, 8'h77, 0); step(0, 1, 0, 8'h88, 0);
      step(0, 1, 1, 8'h99, 0); step(0, 1, 0, 8'hAA, 0);
      step(1, 0, 0, 8'h00, 0); step(0, 1, 0, 8'h12, 0);
      step(0, 1, 1, 8'h10, 0); step(0, 1, 0, 8'h01, 1);
      step(0, 1, 0, 8'h02, 0); step(0, 1, 0, 8'h03, 1);
      step(0, 1, 1, 8'h04, 1); step(0, 0, 0, 8'h00, 0);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) == 0, W'($urandom), $urandom_range(0, 9) == 0);
      step(0, 0, 0, 8'h00, 0);
      n = 0;
      while (q.size() > 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
